// File: rtl/h264quantise.sv
// h264quantise
// Forward scalar quantiser for the H.264 encoder residual path. One transform
// coefficient enters per clock, in the same per-block position order that the
// dequantiser consumes. The block emits a saturated signed 12-bit level three
// cycles later. It also keeps a per-4x4-block count of non-zero AC levels for
// CAVLC nC bookkeeping.
//
// Ports
//   CLK      in   1  clock, rising edge
//   RESET    in   1  synchronous active-high reset
//   ENABLE   in   1  YNIN valid this cycle
//   DCCI     in   1  YNIN is a DC coefficient from a Hadamard stage
//   QP       in   6  quantiser parameter 0..51, sampled with each coefficient
//   INTRA    in   1  1 = intra rounding offset, 0 = inter
//   YNIN     in  16  signed transform coefficient
//   ZOUT     out 12  signed quantised level, -2047..2047, held while VALID=0
//   VALID    out  1  ZOUT valid
//   DCCO     out  1  ZOUT is a DC level
//   LAST     out  1  ZOUT is the position-0 coefficient of a 4x4 block
//   NZCOUNT  out  5  non-zero non-DC levels in the block, valid while LAST=1
module h264quantise (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        DCCI,
  input  logic [5:0]  QP,
  input  logic        INTRA,
  input  logic [15:0] YNIN,
  output logic [11:0] ZOUT,
  output logic        VALID,
  output logic        DCCO,
  output logic        LAST,
  output logic [4:0]  NZCOUNT
);

  localparam logic [1:0] TBL_A = 2'd0;
  localparam logic [1:0] TBL_B = 2'd1;
  localparam logic [1:0] TBL_C = 2'd2;

  // Position class: A holds the (0,0)-type positions, B the (1,1)-type
  // positions and C everything else. DC coefficients always use class A.
  function automatic logic [1:0] table_sel(input logic [3:0] zig, input logic dc);
    if (dc) return TBL_A;
    case (zig)
      4'd0, 4'd3, 4'd5, 4'd11:   return TBL_A;
      4'd4, 4'd10, 4'd12, 4'd15: return TBL_B;
      default:                   return TBL_C;
    endcase
  endfunction

  function automatic logic [13:0] mf_lookup(input logic [1:0] tsel, input logic [2:0] qm);
    logic [13:0] mf;
    mf = 14'd0;
    case (tsel)
      TBL_A: begin
        case (qm)
          3'd0:    mf = 14'd13107;
          3'd1:    mf = 14'd11916;
          3'd2:    mf = 14'd10082;
          3'd3:    mf = 14'd9362;
          3'd4:    mf = 14'd8192;
          default: mf = 14'd7282;
        endcase
      end
      TBL_B: begin
        case (qm)
          3'd0:    mf = 14'd5243;
          3'd1:    mf = 14'd4660;
          3'd2:    mf = 14'd4194;
          3'd3:    mf = 14'd3647;
          3'd4:    mf = 14'd3355;
          default: mf = 14'd2893;
        endcase
      end
      default: begin
        case (qm)
          3'd0:    mf = 14'd8066;
          3'd1:    mf = 14'd7490;
          3'd2:    mf = 14'd6554;
          3'd3:    mf = 14'd5825;
          3'd4:    mf = 14'd5243;
          default: mf = 14'd4559;
        endcase
      end
    endcase
    return mf;
  endfunction

  // Magnitude as an unsigned 16-bit value so that -32768 maps to 32768.
  function automatic logic [15:0] abs16(input logic signed [15:0] v);
    logic [15:0] u;
    u = v;
    return v[15] ? (~u + 16'd1) : u;
  endfunction

  // Rounding offset: 1/3 (intra) or 1/6 (inter) of one quantisation step,
  // scaled with the shift. DC uses one extra shift, so the offset doubles.
  function automatic logic [24:0] round_offset(input logic intra, input logic [3:0] qd,
                                               input logic dc);
    logic [24:0] f;
    f = intra ? 25'd10922 : 25'd5461;
    f = f << qd;
    if (dc) f = f << 1;
    return f;
  endfunction

  function automatic logic [29:0] quant_round(input logic [29:0] prod, input logic [24:0] f,
                                              input logic [4:0] qbits);
    logic [29:0] sum;
    sum = prod + {5'd0, f};
    return sum >> qbits;
  endfunction

  // Clamp the magnitude to 2047 before the sign is applied. This keeps the
  // result symmetric, so -32768 yields -2047 rather than -2048.
  function automatic logic signed [11:0] sat_level(input logic [29:0] mag, input logic neg);
    logic signed [11:0] m;
    m = (mag > 30'd2047) ? 12'sd2047 : $signed({1'b0, mag[10:0]});
    return neg ? -m : m;
  endfunction

  // Input decode
  logic signed [15:0] yn_s;
  logic [3:0]         qd_s0;
  logic [2:0]         qm_s0;
  logic [3:0]         zig_q;
  logic [3:0]         zig_d;

  assign yn_s  = YNIN;
  assign qd_s0 = 4'(QP / 6'd6);
  assign qm_s0 = 3'(QP % 6'd6);

  // The position counter restarts at 15 whenever the coefficient stream
  // breaks (idle cycle) or a DC coefficient interrupts it. It naturally wraps
  // from 0 to 15 between back-to-back blocks.
  always_comb begin
    zig_d = zig_q - 4'd1;
    if (!ENABLE || DCCI) zig_d = 4'd15;
  end

  always_ff @(posedge CLK) begin
    if (RESET) zig_q <= 4'd15;
    else       zig_q <= zig_d;
  end

  // ---- S1: magnitude, sign, multiplier, shift and offset ----
  logic        vld_p1;
  logic        dcc_p1;
  logic        last_p1;
  logic [15:0] a_p1;
  logic        neg_p1;
  logic [13:0] mf_p1;
  logic [4:0]  qbits_p1;
  logic [24:0] f_p1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1  <= 1'b0;
      dcc_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= ENABLE;
      dcc_p1  <= ENABLE & DCCI;
      last_p1 <= ENABLE & ~DCCI & (zig_q == 4'd0);
    end
  end

  always_ff @(posedge CLK) begin
    a_p1     <= abs16(yn_s);
    neg_p1   <= yn_s[15];
    mf_p1    <= mf_lookup(table_sel(zig_q, DCCI), qm_s0);
    qbits_p1 <= 5'd15 + {1'b0, qd_s0} + {4'd0, DCCI};
    f_p1     <= round_offset(INTRA, qd_s0, DCCI);
  end

  // ---- S2: scaled magnitude a*MF ----
  logic        vld_p2;
  logic        dcc_p2;
  logic        last_p2;
  logic [29:0] prod_p2;
  logic        neg_p2;
  logic [4:0]  qbits_p2;
  logic [24:0] f_p2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p2  <= 1'b0;
      dcc_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p2  <= vld_p1;
      dcc_p2  <= dcc_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge CLK) begin
    prod_p2  <= 30'(a_p1) * 30'(mf_p1);
    neg_p2   <= neg_p1;
    qbits_p2 <= qbits_p1;
    f_p2     <= f_p1;
  end

  // ---- S3: round, shift, saturate, sign and output registers ----
  logic signed [11:0] z_lvl;
  logic               nz_hit;
  logic [4:0]         nz_q;
  logic [4:0]         nz_d;

  assign z_lvl  = sat_level(quant_round(prod_p2, f_p2, qbits_p2), neg_p2);
  assign nz_hit = vld_p2 & ~dcc_p2 & (z_lvl != 12'sd0);

  // The running count restarts after a block's final coefficient and on
  // any DC level. A DC level belongs to a separate DC block and never counts.
  always_comb begin
    nz_d = nz_q + {4'd0, nz_hit};
    if (vld_p2 && (dcc_p2 || last_p2)) nz_d = 5'd0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ZOUT    <= 12'd0;
      VALID   <= 1'b0;
      DCCO    <= 1'b0;
      LAST    <= 1'b0;
      NZCOUNT <= 5'd0;
      nz_q    <= 5'd0;
    end else begin
      VALID <= vld_p2;
      DCCO  <= vld_p2 & dcc_p2;
      LAST  <= vld_p2 & last_p2;
      nz_q  <= nz_d;
      if (vld_p2)            ZOUT    <= z_lvl;
      if (vld_p2 && last_p2) NZCOUNT <= nz_q + {4'd0, nz_hit};
    end
  end

endmodule

// File: tb/tb_h264quantise.sv
module tb_h264quantise;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        DCCI = 1'b0;
  logic [5:0]  QP = 6'd0;
  logic        INTRA = 1'b0;
  logic [15:0] YNIN = 16'd0;
  logic [11:0] ZOUT;
  logic        VALID;
  logic        DCCO;
  logic        LAST;
  logic [4:0]  NZCOUNT;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;

  typedef struct {
    bit vld;
    int z;
    bit dcc;
    bit last;
    bit chk_z;
    bit chk_nz;
    int nz;
    int id;
  } exp_t;

  exp_t expq[$];

  always #5 CLK = ~CLK;

  h264quantise dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .DCCI    (DCCI),
    .QP      (QP),
    .INTRA   (INTRA),
    .YNIN    (YNIN),
    .ZOUT    (ZOUT),
    .VALID   (VALID),
    .DCCO    (DCCO),
    .LAST    (LAST),
    .NZCOUNT (NZCOUNT)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: check the output due for the input driven three ticks ago,
  // then drive this tick's inputs and queue what they must produce.
  task automatic tick(input bit rst, input bit en, input bit dc, input int qp, input bit intra,
                      input int y, input exp_t e);
    exp_t r;
    exp_t rz;
    @(negedge CLK);
    if (expq.size() == 3) begin
      r = expq.pop_front();
      check_eq($sformatf("valid#%0d", r.id), {31'd0, VALID}, int'(r.vld));
      check_eq($sformatf("dcco#%0d", r.id), {31'd0, DCCO}, int'(r.dcc));
      check_eq($sformatf("last#%0d", r.id), {31'd0, LAST}, int'(r.last));
      if (r.chk_z)  check_eq($sformatf("zout#%0d", r.id), $signed(ZOUT), r.z);
      if (r.chk_nz) check_eq($sformatf("nzcount#%0d", r.id), {27'd0, NZCOUNT}, r.nz);
    end
    RESET  = rst;
    ENABLE = en;
    DCCI   = dc;
    QP     = 6'(qp);
    INTRA  = intra;
    YNIN   = 16'(y);
    rz = '{vld: 1'b0, z: 0, dcc: 1'b0, last: 1'b0, chk_z: 1'b1, chk_nz: 1'b1, nz: 0, id: 0};
    if (rst) begin
      foreach (expq[i]) begin
        rz.id   = expq[i].id;
        expq[i] = rz;
      end
    end
    e.id = tick_no;
    tick_no++;
    expq.push_back(e);
  endtask

  task automatic rst_tick();
    exp_t e;
    e = '{vld: 1'b0, z: 0, dcc: 1'b0, last: 1'b0, chk_z: 1'b1, chk_nz: 1'b1, nz: 0, id: 0};
    tick(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, e);
  endtask

  task automatic idle(input bit chk, input int hold);
    exp_t e;
    e = '{vld: 1'b0, z: hold, dcc: 1'b0, last: 1'b0, chk_z: chk, chk_nz: 1'b0, nz: 0, id: 0};
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, e);
  endtask

  // enz < 0 means NZCOUNT is not checked for this output.
  task automatic coef(input int qp, input bit intra, input int y, input int ez,
                      input bit elast, input int enz);
    exp_t e;
    e = '{vld: 1'b1, z: ez, dcc: 1'b0, last: elast, chk_z: 1'b1, chk_nz: (enz >= 0),
          nz: enz, id: 0};
    tick(1'b0, 1'b1, 1'b0, qp, intra, y, e);
  endtask

  task automatic dcoef(input int qp, input bit intra, input int y, input int ez);
    exp_t e;
    e = '{vld: 1'b1, z: ez, dcc: 1'b1, last: 1'b0, chk_z: 1'b1, chk_nz: 1'b0, nz: 0, id: 0};
    tick(1'b0, 1'b1, 1'b1, qp, intra, y, e);
  endtask

  task automatic zeros(input int n, input int qp, input bit intra);
    for (int i = 0; i < n; i++) coef(qp, intra, 0, 0, 1'b0, -1);
  endtask

  // Full-block vectors in input order (zig 15 down to 0), QP=0.
  int b1_y[16] = '{100, 0, -50, 1, 0, 0, 3, 0, 0, 0, -2, 0, 0, 2, 0, 2};
  int b1_z[16] = '{16, 0, -12, 0, 0, 0, 1, 0, 0, 0, -1, 0, 0, 0, 0, 1};
  int b2_y[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 2};
  int b2_z[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int rb_y[7]  = '{100, 100, 100, 100, 100, 100, 100};
  int rb_z[5]  = '{16, 24, 24, 16, 40};

  initial begin
    // Reset state
    rst_tick();
    rst_tick();
    rst_tick();

    // Deadzone at QP=0 intra, table A at zig 0
    zeros(15, 0, 1'b1);
    coef(0, 1'b1, 1, 0, 1'b1, 0);
    zeros(15, 0, 1'b1);
    coef(0, 1'b1, 2, 1, 1'b1, 1);

    // Sign handling at QP=28
    zeros(15, 28, 1'b1);
    coef(28, 1'b1, 1000, 15, 1'b1, 1);
    zeros(15, 28, 1'b1);
    coef(28, 1'b1, -1000, -15, 1'b1, 1);

    // Saturation, then ZOUT must hold across idle cycles
    zeros(15, 0, 1'b1);
    coef(0, 1'b1, 32767, 2047, 1'b1, 1);
    zeros(15, 0, 1'b1);
    coef(0, 1'b1, -32768, -2047, 1'b1, 1);
    idle(1'b1, -2047);
    idle(1'b1, -2047);

    // DC landing on zig 0 is not LAST; the next coefficient restarts at zig 15
    zeros(15, 0, 1'b1);
    dcoef(0, 1'b1, 100, 20);
    coef(0, 1'b1, 100, 16, 1'b0, -1);
    zeros(14, 0, 1'b1);
    coef(0, 1'b1, 0, 0, 1'b1, 1);

    // Two full blocks back to back
    for (int i = 0; i < 16; i++)
      coef(0, 1'b1, b1_y[i], b1_z[i], (i == 15), (i == 15) ? 5 : -1);
    for (int i = 0; i < 16; i++)
      coef(0, 1'b0, b2_y[i], b2_z[i], (i == 15), (i == 15) ? 1 : -1);

    // Reset after 7 coefficients; the last two in flight must vanish
    for (int i = 0; i < 7; i++)
      coef(0, 1'b1, rb_y[i], (i < 5) ? rb_z[i] : 0, 1'b0, -1);
    rst_tick();
    idle(1'b1, 0);
    idle(1'b1, 0);
    idle(1'b1, 0);
    coef(6, 1'b1, 300, 24, 1'b0, -1);
    zeros(14, 6, 1'b1);
    coef(6, 1'b1, 1000, 200, 1'b1, 2);

    idle(1'b0, 0);
    idle(1'b0, 0);
    idle(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
